// File: rtl/geri_yaz.sv
// ---------------------------------------------------------------------------
// geri_yaz - writeback stage
//
// Merges single-cycle execute results and handshaked memory-load results
// onto the single register-file write port. Execute results always win the
// port. Loads that lose arbitration wait in a small in-order FIFO, and
// bellek_hazir_o drops while that FIFO is full. All writeback outputs are
// registered, so there is one cycle of latency.
//
// Optional build macro:
//   GERIYAZ_SAYAC_EN - adds a 32-bit retired-write counter on geriyaz_sayac_o
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   yurut_*_i           execute result (valid, write-enable, data, rd, tag)
//   bellek_gecerli_i    load result valid
//   bellek_hazir_o      stage accepts a load result this cycle
//   bellek_*_i          load result fields (data, rd, tag)
//   geriyaz_*_o         register-file write port (data, rd, tag, valid)
//   geriyaz_sayac_o     retired write count (GERIYAZ_SAYAC_EN only)
// ---------------------------------------------------------------------------
module geri_yaz #(
  parameter int VERI_BIT        = 32,
  parameter int YAZMAC_BIT      = 5,
  parameter int ETIKET_BIT      = 4,
  parameter int KUYRUK_DERINLIK = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  yurut_gecerli_i,
  input  logic                  yurut_yaz_i,
  input  logic [VERI_BIT-1:0]   yurut_veri_i,
  input  logic [YAZMAC_BIT-1:0] yurut_adres_i,
  input  logic [ETIKET_BIT-1:0] yurut_etiket_i,
  input  logic                  bellek_gecerli_i,
  output logic                  bellek_hazir_o,
  input  logic [VERI_BIT-1:0]   bellek_veri_i,
  input  logic [YAZMAC_BIT-1:0] bellek_adres_i,
  input  logic [ETIKET_BIT-1:0] bellek_etiket_i,
  output logic [VERI_BIT-1:0]   geriyaz_veri_o,
  output logic [YAZMAC_BIT-1:0] geriyaz_adres_o,
  output logic [ETIKET_BIT-1:0] geriyaz_etiket_o,
`ifdef GERIYAZ_SAYAC_EN
  output logic [31:0]           geriyaz_sayac_o,
`endif
  output logic                  geriyaz_gecerli_o
);

  // Depth is a power of two, so the pointers wrap on their own.
  localparam int PTR_BIT = (KUYRUK_DERINLIK > 1) ? $clog2(KUYRUK_DERINLIK) : 1;
  localparam int SAY_BIT = $clog2(KUYRUK_DERINLIK + 1);

  localparam logic [PTR_BIT-1:0] PTR_BIR = PTR_BIT'(1);
  localparam logic [SAY_BIT-1:0] SAY_BIR = SAY_BIT'(1);
  localparam logic [SAY_BIT-1:0] DOLU    = SAY_BIT'(KUYRUK_DERINLIK);

  logic [VERI_BIT-1:0]   kuyruk_veri   [KUYRUK_DERINLIK];
  logic [YAZMAC_BIT-1:0] kuyruk_adres  [KUYRUK_DERINLIK];
  logic [ETIKET_BIT-1:0] kuyruk_etiket [KUYRUK_DERINLIK];

  logic [PTR_BIT-1:0] yaz_ptr;
  logic [PTR_BIT-1:0] oku_ptr;
  logic [SAY_BIT-1:0] sayi;

  logic yurut_istek;
  logic aktarim;
  logic yukle_gecerli;
  logic bos;
  logic push;
  logic pop;

  logic                  sec_gecerli;
  logic [VERI_BIT-1:0]   sec_veri;
  logic [YAZMAC_BIT-1:0] sec_adres;
  logic [ETIKET_BIT-1:0] sec_etiket;

  // Ready depends only on the registered count, never on this cycle's
  // traffic, so a pop in the same cycle cannot open a slot for a push.
  assign bellek_hazir_o = !rst_i && (sayi < DOLU);

  assign yurut_istek   = yurut_gecerli_i && yurut_yaz_i && (yurut_adres_i != '0);
  assign aktarim       = bellek_gecerli_i && bellek_hazir_o;
  assign yukle_gecerli = aktarim && (bellek_adres_i != '0);
  assign bos           = (sayi == '0);

  // The head only leaves when execute is idle; an incoming load must queue
  // whenever it cannot bypass, which keeps loads in acceptance order.
  assign pop  = !yurut_istek && !bos;
  assign push = yukle_gecerli && (yurut_istek || !bos);

  // Slot winner: execute, then FIFO head, then a bypassed load.
  always_comb begin
    sec_gecerli = 1'b0;
    sec_veri    = yurut_veri_i;
    sec_adres   = yurut_adres_i;
    sec_etiket  = yurut_etiket_i;
    if (yurut_istek) begin
      sec_gecerli = 1'b1;
    end else if (!bos) begin
      sec_gecerli = 1'b1;
      sec_veri    = kuyruk_veri[oku_ptr];
      sec_adres   = kuyruk_adres[oku_ptr];
      sec_etiket  = kuyruk_etiket[oku_ptr];
    end else if (yukle_gecerli) begin
      sec_gecerli = 1'b1;
      sec_veri    = bellek_veri_i;
      sec_adres   = bellek_adres_i;
      sec_etiket  = bellek_etiket_i;
    end
  end

  // FIFO storage needs no reset: only entries below the count are read.
  always_ff @(posedge clk_i) begin
    if (push) begin
      kuyruk_veri[yaz_ptr]   <= bellek_veri_i;
      kuyruk_adres[yaz_ptr]  <= bellek_adres_i;
      kuyruk_etiket[yaz_ptr] <= bellek_etiket_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      yaz_ptr <= '0;
      oku_ptr <= '0;
      sayi    <= '0;
    end else begin
      if (push) yaz_ptr <= yaz_ptr + PTR_BIR;
      if (pop)  oku_ptr <= oku_ptr + PTR_BIR;
      case ({push, pop})
        2'b10:   sayi <= sayi + SAY_BIR;
        2'b01:   sayi <= sayi - SAY_BIR;
        default: sayi <= sayi;
      endcase
    end
  end

  // Data, address and tag only update when a result wins, so they hold
  // their last value through idle cycles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      geriyaz_gecerli_o <= 1'b0;
      geriyaz_veri_o    <= '0;
      geriyaz_adres_o   <= '0;
      geriyaz_etiket_o  <= '0;
    end else begin
      geriyaz_gecerli_o <= sec_gecerli;
      if (sec_gecerli) begin
        geriyaz_veri_o   <= sec_veri;
        geriyaz_adres_o  <= sec_adres;
        geriyaz_etiket_o <= sec_etiket;
      end
    end
  end

`ifdef GERIYAZ_SAYAC_EN
  logic [31:0] sayac_q;

  // Counts cycles with a write on the port; wraps naturally at 2^32.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sayac_q <= '0;
    end else if (geriyaz_gecerli_o) begin
      sayac_q <= sayac_q + 32'd1;
    end
  end

  assign geriyaz_sayac_o = sayac_q;
`else
  // No retired-write counter in this build.
`endif

endmodule

// File: tb/tb_geri_yaz.sv
// ---------------------------------------------------------------------------
// tb_geri_yaz - self-checking bench for geri_yaz
//
// A behavioural model of the write slot and load queue predicts each
// cycle's winner; predicted writes go into a scoreboard queue and are
// popped and compared when the port shows a write. Compile with
// GERIYAZ_SAYAC_EN to also exercise the retired-write counter.
// ---------------------------------------------------------------------------
module tb_geri_yaz;

  typedef struct packed {
    logic [4:0]  adres;
    logic [31:0] veri;
    logic [3:0]  etiket;
  } sonuc_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        yurut_gecerli_i = 1'b0;
  logic        yurut_yaz_i = 1'b0;
  logic [31:0] yurut_veri_i = '0;
  logic [4:0]  yurut_adres_i = '0;
  logic [3:0]  yurut_etiket_i = '0;
  logic        bellek_gecerli_i = 1'b0;
  logic        bellek_hazir_o;
  logic [31:0] bellek_veri_i = '0;
  logic [4:0]  bellek_adres_i = '0;
  logic [3:0]  bellek_etiket_i = '0;
  logic [31:0] geriyaz_veri_o;
  logic [4:0]  geriyaz_adres_o;
  logic [3:0]  geriyaz_etiket_o;
  logic        geriyaz_gecerli_o;
`ifdef GERIYAZ_SAYAC_EN
  logic [31:0] geriyaz_sayac_o;
`endif

  geri_yaz dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .yurut_gecerli_i  (yurut_gecerli_i),
    .yurut_yaz_i      (yurut_yaz_i),
    .yurut_veri_i     (yurut_veri_i),
    .yurut_adres_i    (yurut_adres_i),
    .yurut_etiket_i   (yurut_etiket_i),
    .bellek_gecerli_i (bellek_gecerli_i),
    .bellek_hazir_o   (bellek_hazir_o),
    .bellek_veri_i    (bellek_veri_i),
    .bellek_adres_i   (bellek_adres_i),
    .bellek_etiket_i  (bellek_etiket_i),
    .geriyaz_veri_o   (geriyaz_veri_o),
    .geriyaz_adres_o  (geriyaz_adres_o),
    .geriyaz_etiket_o (geriyaz_etiket_o),
`ifdef GERIYAZ_SAYAC_EN
    .geriyaz_sayac_o  (geriyaz_sayac_o),
`endif
    .geriyaz_gecerli_o(geriyaz_gecerli_o)
  );

  always #5 clk_i = ~clk_i;

  int          assert_count = 0;
  int          fail_count   = 0;
  sonuc_t      mem_q[$];
  sonuc_t      exp_q[$];
  sonuc_t      son;
  logic [31:0] model_sayac;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drives one cycle of stimulus, predicts the slot winner, and checks the
  // registered port one cycle later.
  task automatic applyStimulus(input logic ev, input logic ey, input logic [4:0] ea,
                               input logic [31:0] ed, input logic [3:0] et,
                               input logic mv, input logic [4:0] ma,
                               input logic [31:0] md, input logic [3:0] mt);
    logic   model_hazir;
    logic   exec_req;
    logic   load_ok;
    logic   have;
    sonuc_t win;
    sonuc_t ld;
    sonuc_t e;
    @(negedge clk_i);
    yurut_gecerli_i  = ev;
    yurut_yaz_i      = ey;
    yurut_adres_i    = ea;
    yurut_veri_i     = ed;
    yurut_etiket_i   = et;
    bellek_gecerli_i = mv;
    bellek_adres_i   = ma;
    bellek_veri_i    = md;
    bellek_etiket_i  = mt;
    #1;
    model_hazir = (mem_q.size() < 2);
    checkOutput("hazir", {31'd0, bellek_hazir_o}, {31'd0, model_hazir});
    exec_req = ev && ey && (ea != 5'd0);
    load_ok  = mv && model_hazir && (ma != 5'd0);
    ld   = '{adres: ma, veri: md, etiket: mt};
    have = 1'b0;
    win  = '0;
    if (exec_req) begin
      win  = '{adres: ea, veri: ed, etiket: et};
      have = 1'b1;
      if (load_ok) mem_q.push_back(ld);
    end else if (mem_q.size() > 0) begin
      win  = mem_q.pop_front();
      have = 1'b1;
      if (load_ok) mem_q.push_back(ld);
    end else if (load_ok) begin
      win  = ld;
      have = 1'b1;
    end
    if (have) exp_q.push_back(win);
    @(posedge clk_i);
    #1;
    checkOutput("gecerli", {31'd0, geriyaz_gecerli_o}, {31'd0, have});
    if (geriyaz_gecerli_o && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput("adres", {27'd0, geriyaz_adres_o}, {27'd0, e.adres});
      checkOutput("veri", geriyaz_veri_o, e.veri);
      checkOutput("etiket", {28'd0, geriyaz_etiket_o}, {28'd0, e.etiket});
      son = e;
      model_sayac = model_sayac + 32'd1;
    end else if (!geriyaz_gecerli_o) begin
      checkOutput("veri_tut", geriyaz_veri_o, son.veri);
      checkOutput("adres_tut", {27'd0, geriyaz_adres_o}, {27'd0, son.adres});
    end
`ifdef GERIYAZ_SAYAC_EN
    checkOutput("sayac", geriyaz_sayac_o, model_sayac);
`endif
  endtask

  // One reset cycle; checks reset values and ready behaviour around it.
  task automatic pulseReset();
    @(negedge clk_i);
    rst_i            = 1'b1;
    yurut_gecerli_i  = 1'b0;
    bellek_gecerli_i = 1'b0;
    #1;
    checkOutput("hazir_rst", {31'd0, bellek_hazir_o}, 32'd0);
    @(posedge clk_i);
    #1;
    checkOutput("rst_gecerli", {31'd0, geriyaz_gecerli_o}, 32'd0);
    checkOutput("rst_veri", geriyaz_veri_o, 32'd0);
    checkOutput("rst_adres", {27'd0, geriyaz_adres_o}, 32'd0);
    checkOutput("rst_etiket", {28'd0, geriyaz_etiket_o}, 32'd0);
`ifdef GERIYAZ_SAYAC_EN
    checkOutput("rst_sayac", geriyaz_sayac_o, 32'd0);
`endif
    rst_i = 1'b0;
    #1;
    checkOutput("hazir_sonra", {31'd0, bellek_hazir_o}, 32'd1);
    mem_q.delete();
    exp_q.delete();
    son         = '0;
    model_sayac = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    son         = '0;
    model_sayac = '0;
    pulseReset();

    $display("[TB] single execute write");
    applyStimulus(1, 1, 5'd3, 32'h1234, 4'd5, 0, 0, 0, 0);
    idle(2);

    $display("[TB] bypass when execute leaves the slot free");
    applyStimulus(1, 1, 5'd0, 32'h5555, 4'd1, 1, 5'd7, 32'hAA, 4'd2);
    applyStimulus(1, 0, 5'd9, 32'h6666, 4'd3, 1, 5'd8, 32'hBB, 4'd4);
    idle(1);

    $display("[TB] queued loads retire in order behind execute");
    applyStimulus(1, 1, 5'd1, 32'h11, 4'd1, 1, 5'd2, 32'h22, 4'd2);
    applyStimulus(1, 1, 5'd1, 32'h12, 4'd3, 1, 5'd4, 32'h44, 4'd4);
    idle(3);

    $display("[TB] sustained execute fills the queue");
    for (int i = 0; i < 4; i++)
      applyStimulus(1, 1, 5'(10 + i), 32'h100 + i, 4'(i), 1, 5'(20 + i),
                    32'h200 + i, 4'(8 + i));
    idle(4);

    $display("[TB] load to x0 is discarded");
    applyStimulus(0, 0, 0, 0, 0, 1, 5'd0, 32'hDEAD, 4'd6);
    applyStimulus(1, 1, 5'd5, 32'h55, 4'd7, 1, 5'd0, 32'hBEEF, 4'd6);
    idle(2);

    $display("[TB] reset drops queued entries");
    applyStimulus(1, 1, 5'd6, 32'h66, 4'd1, 1, 5'd12, 32'hC0, 4'd2);
    applyStimulus(1, 1, 5'd6, 32'h67, 4'd1, 1, 5'd13, 32'hC1, 4'd3);
    pulseReset();
    idle(3);

    $display("[TB] random traffic");
    for (int i = 0; i < 300; i++)
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                    5'($urandom_range(0, 3)), $urandom, 4'($urandom),
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                    $urandom, 4'($urandom));
    idle(4);

`ifdef GERIYAZ_SAYAC_EN
    $display("[TB] retired-write counter");
    pulseReset();
    for (int i = 0; i < 10; i++)
      applyStimulus(1, 1, 5'(i + 1), 32'(i), 4'(i), 0, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      applyStimulus(1, 1, 5'd0, 32'(i), 4'(i), 0, 0, 0, 0);
    idle(1);
    checkOutput("sayac_10", geriyaz_sayac_o, 32'd10);
    @(negedge clk_i);
    force dut.sayac_q = 32'hFFFF_FFFF;
    #1;
    release dut.sayac_q;
    model_sayac = 32'hFFFF_FFFF;
    applyStimulus(1, 1, 5'd3, 32'h3, 4'd3, 0, 0, 0, 0);
    idle(1);
    checkOutput("sayac_wrap", geriyaz_sayac_o, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             assert_count, fail_count);
    $finish;
  end

endmodule
